// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF response sequencer.
package ro_puf_pkg;
    localparam int COUNT_W            = 32;
    localparam int DEF_N_PAIRS        = 8;
    localparam int DEF_WINDOW_CYCLES  = 1000;
    localparam int DEF_TIMEOUT_MARGIN = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START_A = 3'd1,
        ST_WAIT_A  = 3'd2,
        ST_START_B = 3'd3,
        ST_WAIT_B  = 3'd4,
        ST_COMPARE = 3'd5,
        ST_DONE    = 3'd6
    } state_e;
endpackage

// File: rtl/ro_puf_sequencer_if.sv
// Host and RO-counter signals of the PUF sequencer; master is the sequencer side.
interface ro_puf_sequencer_if
    import ro_puf_pkg::*;
#(
    parameter int N_PAIRS = DEF_N_PAIRS
);
    localparam int SEL_W = $clog2(2 * N_PAIRS);

    // start_in is a level request sampled only in IDLE; cnt_start/cnt_done and
    // resp_valid are single-cycle pulses with no back-pressure.
    logic               start_in;
    logic               busy;
    logic [SEL_W-1:0]   ro_sel;
    logic               cnt_start;
    logic [COUNT_W-1:0] window_cycles;
    logic               cnt_done;
    logic [COUNT_W-1:0] cnt_count;
    logic [N_PAIRS-1:0] response;
    logic [N_PAIRS-1:0] tie_mask;
    logic               resp_valid;
    logic               err;
    logic [2:0]         state;

    modport master (
        input  start_in, cnt_done, cnt_count,
        output busy, ro_sel, cnt_start, window_cycles, response, tie_mask,
               resp_valid, err, state
    );

    modport slave (
        output start_in, cnt_done, cnt_count,
        input  busy, ro_sel, cnt_start, window_cycles, response, tie_mask,
               resp_valid, err, state
    );
endinterface

// File: rtl/ro_puf_sequencer.sv
// Walks every RO pair through the shared counter (A then B), builds the
// response and tie mask, and aborts with a sticky error if a window never ends.
module ro_puf_sequencer
    import ro_puf_pkg::*;
#(
    parameter int N_PAIRS        = DEF_N_PAIRS,
    parameter int WINDOW_CYCLES  = DEF_WINDOW_CYCLES,
    parameter int TIMEOUT_MARGIN = DEF_TIMEOUT_MARGIN
) (
    input  logic               clk_ref,
    input  logic               rst,
    ro_puf_sequencer_if.master bus
);
    localparam int SEL_W  = $clog2(2 * N_PAIRS);
    localparam int PAIR_W = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] START_A = ST_START_A;
    localparam logic [2:0] WAIT_A  = ST_WAIT_A;
    localparam logic [2:0] START_B = ST_START_B;
    localparam logic [2:0] WAIT_B  = ST_WAIT_B;
    localparam logic [2:0] COMPARE = ST_COMPARE;
    localparam logic [2:0] DONE    = ST_DONE;

    localparam logic [COUNT_W-1:0] WDOG_LAST = COUNT_W'(WINDOW_CYCLES + TIMEOUT_MARGIN - 1);
    localparam logic [PAIR_W-1:0]  PAIR_LAST = PAIR_W'(N_PAIRS - 1);

    logic [2:0]         state;
    logic [PAIR_W-1:0]  pair;
    logic [PAIR_W-1:0]  pair_nxt;
    logic [SEL_W-1:0]   ro_sel;
    logic [COUNT_W-1:0] count_a;
    logic [COUNT_W-1:0] count_b;
    logic [COUNT_W-1:0] wdog;
    logic [N_PAIRS-1:0] response;
    logic [N_PAIRS-1:0] tie_mask;
    logic               err;

    assign pair_nxt = pair + PAIR_W'(1);

    // ro_sel is registered so it only moves on the edge that enters START_x.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pair     <= '0;
            ro_sel   <= '0;
            count_a  <= '0;
            count_b  <= '0;
            wdog     <= '0;
            response <= '0;
            tie_mask <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        pair     <= '0;
                        ro_sel   <= '0;
                        response <= '0;
                        tie_mask <= '0;
                        err      <= 1'b0;
                        state    <= START_A;
                    end
                end
                START_A: begin
                    wdog  <= '0;
                    state <= WAIT_A;
                end
                WAIT_A: begin
                    if (bus.cnt_done) begin
                        count_a <= bus.cnt_count;
                        ro_sel  <= SEL_W'({pair, 1'b1});
                        state   <= START_B;
                    end else if (wdog == WDOG_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + COUNT_W'(1);
                    end
                end
                START_B: begin
                    wdog  <= '0;
                    state <= WAIT_B;
                end
                WAIT_B: begin
                    if (bus.cnt_done) begin
                        count_b <= bus.cnt_count;
                        state   <= COMPARE;
                    end else if (wdog == WDOG_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + COUNT_W'(1);
                    end
                end
                COMPARE: begin
                    response[pair] <= (count_a > count_b);
                    tie_mask[pair] <= (count_a == count_b);
                    if (pair == PAIR_LAST) begin
                        state <= DONE;
                    end else begin
                        pair   <= pair_nxt;
                        ro_sel <= SEL_W'({pair_nxt, 1'b0});
                        state  <= START_A;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.cnt_start     = (state == START_A) || (state == START_B);
    assign bus.resp_valid    = (state == DONE);
    assign bus.ro_sel        = ro_sel;
    assign bus.window_cycles = COUNT_W'(WINDOW_CYCLES);
    assign bus.response      = response;
    assign bus.tie_mask      = tie_mask;
    assign bus.err           = err;
    assign bus.state         = state;
endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer with a behavioural RO counter model.
module tb_ro_puf_sequencer;
    import ro_puf_pkg::*;

    localparam int NP  = 2;
    localparam int WIN = 20;
    localparam int MRG = 8;
    localparam int LAT = 3;

    typedef struct {
        logic [31:0] a0, b0, a1, b1;
        logic [1:0]  resp;
        logic [1:0]  tie;
    } vec_t;

    logic clk_ref = 1'b0;
    logic rst     = 1'b1;

    ro_puf_sequencer_if #(.N_PAIRS(NP)) bus ();

    ro_puf_sequencer #(
        .N_PAIRS(NP), .WINDOW_CYCLES(WIN), .TIMEOUT_MARGIN(MRG)
    ) dut (
        .clk_ref(clk_ref),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_ref = ~clk_ref;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Counter model: answers a cnt_start LAT cycles later with the count for that RO.
    logic [31:0] cnt_tab[4];
    logic        model_en = 1'b1;
    logic        spur_en  = 1'b0;
    int          pend_cnt = 0;
    logic [1:0]  pend_sel = '0;

    initial begin
        bus.cnt_done  = 1'b0;
        bus.cnt_count = '0;
        forever begin
            @(negedge clk_ref);
            bus.cnt_done = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.cnt_done  = 1'b1;
                    bus.cnt_count = cnt_tab[pend_sel];
                    check("ro_sel_stable", 64'(bus.ro_sel), 64'(pend_sel));
                end
            end
            if (bus.cnt_start && model_en) begin
                pend_sel = bus.ro_sel;
                pend_cnt = LAT;
            end
            if (spur_en && bus.state == 3'd5) begin
                bus.cnt_done  = 1'b1;
                bus.cnt_count = 32'hdead_beef;
            end
        end
    end

    // Pulse monitor
    int   start_cnt = 0;
    int   rv_cnt    = 0;
    logic [1:0] sel_q[$];

    initial begin
        forever begin
            @(negedge clk_ref);
            if (bus.cnt_start) begin
                start_cnt++;
                sel_q.push_back(bus.ro_sel);
            end
            if (bus.resp_valid) rv_cnt++;
        end
    end

    task automatic clear_mon();
        start_cnt = 0;
        rv_cnt    = 0;
        sel_q.delete();
    endtask

    task automatic load_vec(input vec_t v);
        cnt_tab[0] = v.a0;
        cnt_tab[1] = v.b0;
        cnt_tab[2] = v.a1;
        cnt_tab[3] = v.b1;
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_ref);
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_idle_reached"}, 64'(done), 64'd1);
    endtask

    task automatic check_result(input vec_t v, input string tag);
        check({tag, "_response"}, 64'(bus.response), 64'(v.resp));
        check({tag, "_tie_mask"}, 64'(bus.tie_mask), 64'(v.tie));
        check({tag, "_resp_valid_cnt"}, 64'(rv_cnt), 64'd1);
        check({tag, "_cnt_start_cnt"}, 64'(start_cnt), 64'd4);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
        check({tag, "_sel_q_size"}, 64'(sel_q.size()), 64'd4);
        for (int i = 0; i < sel_q.size() && i < 4; i++)
            check({tag, "_ro_sel_seq"}, 64'(sel_q[i]), 64'(i));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        load_vec(v);
        clear_mon();
        @(negedge clk_ref);
        bus.start_in = 1'b1;
        @(negedge clk_ref);
        bus.start_in = 1'b0;
        check({tag, "_busy_k1"}, 64'(bus.busy), 64'd1);
        check({tag, "_cnt_start_k1"}, 64'(bus.cnt_start), 64'd1);
        check({tag, "_err_cleared"}, 64'(bus.err), 64'd0);
        wait_idle(tag);
        repeat (2) @(negedge clk_ref);
        check_result(v, tag);
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        logic hit;
        bus.start_in = 1'b0;

        vecs[0] = '{a0: 32'd120, b0: 32'd100, a1: 32'd90, b1: 32'd95, resp: 2'b01, tie: 2'b00};
        vecs[1] = '{a0: 32'd77, b0: 32'd77, a1: 32'd5, b1: 32'd3, resp: 2'b10, tie: 2'b01};
        vecs[2] = '{a0: 32'd0, b0: 32'd1, a1: 32'hffff_ffff, b1: 32'd0, resp: 2'b10, tie: 2'b00};
        vecs[3] = '{a0: 32'd5, b0: 32'd5, a1: 32'd7, b1: 32'd7, resp: 2'b00, tie: 2'b11};
        vecs[4] = '{a0: 32'd200, b0: 32'd100, a1: 32'd300, b1: 32'd299, resp: 2'b11, tie: 2'b00};

        // Reset state
        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_cnt_start", 64'(bus.cnt_start), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_response", 64'(bus.response), 64'd0);
        check("rst_tie_mask", 64'(bus.tie_mask), 64'd0);
        check("rst_ro_sel", 64'(bus.ro_sel), 64'd0);
        check("rst_state", 64'(bus.state), 64'd0);
        check("window_cycles", 64'(bus.window_cycles), 64'(WIN));
        @(negedge clk_ref);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Watchdog: counter never answers
        model_en = 1'b0;
        clear_mon();
        @(negedge clk_ref);
        bus.start_in = 1'b1;
        @(negedge clk_ref);
        bus.start_in = 1'b0;
        n = 0;
        while (!bus.err && n < 100) begin
            @(negedge clk_ref);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(WIN + MRG + 1));
        check("timeout_err", 64'(bus.err), 64'd1);
        check("timeout_busy", 64'(bus.busy), 64'd0);
        check("timeout_state", 64'(bus.state), 64'd0);
        repeat (3) @(negedge clk_ref);
        check("timeout_no_resp_valid", 64'(rv_cnt), 64'd0);
        check("timeout_err_sticky", 64'(bus.err), 64'd1);
        model_en = 1'b1;
        run_vec(vecs[0], "after_timeout");

        // Reset during WAIT_B of pair 1
        load_vec(vecs[0]);
        clear_mon();
        @(negedge clk_ref);
        bus.start_in = 1'b1;
        @(negedge clk_ref);
        bus.start_in = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_ref);
            if (bus.state == 3'd4 && bus.ro_sel == 2'd3) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_wait_b_pair1", 64'(hit), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_response", 64'(bus.response), 64'd0);
        check("midrst_tie_mask", 64'(bus.tie_mask), 64'd0);
        check("midrst_ro_sel", 64'(bus.ro_sel), 64'd0);
        check("midrst_err", 64'(bus.err), 64'd0);
        check("midrst_state", 64'(bus.state), 64'd0);
        check("midrst_no_resp_valid", 64'(rv_cnt), 64'd0);
        pend_cnt = 0;
        @(negedge clk_ref);
        rst = 1'b0;
        pend_cnt = 0;
        run_vec(vecs[1], "after_rst");

        // start_in held high through a run, spurious cnt_done in COMPARE
        load_vec(vecs[4]);
        clear_mon();
        spur_en = 1'b1;
        @(negedge clk_ref);
        bus.start_in = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_ref);
            if (bus.resp_valid) begin
                bus.start_in = 1'b0;
                hit = 1'b1;
                break;
            end
        end
        bus.start_in = 1'b0;
        spur_en = 1'b0;
        check("held_start_done", 64'(hit), 64'd1);
        repeat (4) @(negedge clk_ref);
        check("held_start_idle", 64'(bus.busy), 64'd0);
        check_result(vecs[4], "held_start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
